// File: rtl/lcd_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_init_sequencer
// Function : HD44780-style power-on init sequencer, paced by a 15 ms timer.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_init_sequencer #(
   parameter int SETUP_CYCLES  = 2,
   parameter int E_CYCLES      = 12,
   parameter int HOLD_CYCLES   = 2,
   parameter int POWERUP_TICKS = 1,
   parameter int CMD_TICKS     = 1
) (
   input  logic       clock,
   input  logic       rst,
   input  logic       start,
   input  logic       timer_pulse,
   output logic       timer_enable,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_e,
   output logic [7:0] lcd_data,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PWR_WAIT = 3'd1,
      S_SETUP    = 3'd2,
      S_E_HIGH   = 3'd3,
      S_HOLD     = 3'd4,
      S_CMD_WAIT = 3'd5,
      S_DONE     = 3'd6
   } state_t;

   localparam logic [7:0] c_setup_load = 8'(SETUP_CYCLES - 1);
   localparam logic [7:0] c_e_load     = 8'(E_CYCLES - 1);
   localparam logic [7:0] c_hold_load  = 8'(HOLD_CYCLES - 1);
   localparam logic [3:0] c_pwr_ticks  = 4'(POWERUP_TICKS);
   localparam logic [3:0] c_cmd_ticks  = 4'(CMD_TICKS);
   localparam logic [2:0] c_last_idx   = 3'd7;

   function automatic logic [7:0] cmd_rom(input logic [2:0] idx);
      logic [7:0] v;
      case (idx)
         3'd0:    v = 8'h30;
         3'd1:    v = 8'h30;
         3'd2:    v = 8'h30;
         3'd3:    v = 8'h38;
         3'd4:    v = 8'h08;
         3'd5:    v = 8'h01;
         3'd6:    v = 8'h06;
         default: v = 8'h0C;
      endcase
      return v;
   endfunction

   state_t      r_state;
   logic [7:0]  r_cnt;
   logic [3:0]  r_ticks;
   logic [2:0]  r_idx;
   logic        r_timer_enable;
   logic        r_lcd_e;
   logic [7:0]  r_lcd_data;
   logic        r_busy;
   logic        r_done;

   state_t      w_state_nxt;
   logic [7:0]  w_cnt_nxt;
   logic [3:0]  w_ticks_nxt;
   logic [2:0]  w_idx_nxt;
   logic [7:0]  w_data_nxt;
   logic [3:0]  w_tick_inc;
   logic [2:0]  w_idx_inc;
   logic        w_timer_enable_nxt;
   logic        w_lcd_e_nxt;
   logic        w_busy_nxt;
   logic        w_done_nxt;

   assign w_tick_inc = r_ticks + 4'd1;
   assign w_idx_inc  = r_idx + 3'd1;

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         r_state        <= S_IDLE;
         r_cnt          <= '0;
         r_ticks        <= '0;
         r_idx          <= '0;
         r_timer_enable <= 1'b0;
         r_lcd_e        <= 1'b0;
         r_lcd_data     <= '0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_cnt          <= w_cnt_nxt;
         r_ticks        <= w_ticks_nxt;
         r_idx          <= w_idx_nxt;
         r_timer_enable <= w_timer_enable_nxt;
         r_lcd_e        <= w_lcd_e_nxt;
         r_lcd_data     <= w_data_nxt;
         r_busy         <= w_busy_nxt;
         r_done         <= w_done_nxt;
      end
   end

   // Outputs are decoded from the next state so every registered output
   // lines up cycle-for-cycle with the state it belongs to.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ticks_nxt = r_ticks;
      w_idx_nxt   = r_idx;
      w_data_nxt  = r_lcd_data;

      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_nxt = S_PWR_WAIT;
               w_ticks_nxt = '0;
            end
         end

         S_PWR_WAIT: begin
            if (timer_pulse) begin
               w_ticks_nxt = w_tick_inc;
               if (w_tick_inc == c_pwr_ticks) begin
                  w_state_nxt = S_SETUP;
                  w_idx_nxt   = '0;
                  w_cnt_nxt   = c_setup_load;
                  w_data_nxt  = cmd_rom(3'd0);
               end
            end
         end

         S_SETUP: begin
            if (r_cnt == 8'd0) begin
               w_state_nxt = S_E_HIGH;
               w_cnt_nxt   = c_e_load;
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end

         S_E_HIGH: begin
            if (r_cnt == 8'd0) begin
               w_state_nxt = S_HOLD;
               w_cnt_nxt   = c_hold_load;
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end

         S_HOLD: begin
            if (r_cnt == 8'd0) begin
               w_state_nxt = S_CMD_WAIT;
               w_ticks_nxt = '0;
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end

         S_CMD_WAIT: begin
            if (timer_pulse) begin
               w_ticks_nxt = w_tick_inc;
               if (w_tick_inc == c_cmd_ticks) begin
                  if (r_idx == c_last_idx) begin
                     w_state_nxt = S_DONE;
                  end else begin
                     w_state_nxt = S_SETUP;
                     w_idx_nxt   = w_idx_inc;
                     w_cnt_nxt   = c_setup_load;
                     w_data_nxt  = cmd_rom(w_idx_inc);
                  end
               end
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      w_timer_enable_nxt = (w_state_nxt == S_PWR_WAIT) || (w_state_nxt == S_CMD_WAIT);
      w_lcd_e_nxt        = (w_state_nxt == S_E_HIGH);
      w_busy_nxt         = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
      w_done_nxt         = (w_state_nxt == S_DONE);
   end

   assign timer_enable = r_timer_enable;
   assign lcd_rs       = 1'b0;
   assign lcd_rw       = 1'b0;
   assign lcd_e        = r_lcd_e;
   assign lcd_data     = r_lcd_data;
   assign busy         = r_busy;
   assign done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_lcd_init_sequencer.sv
`default_nettype none
// Bench for lcd_init_sequencer: vector table, timing model runs, reset abort.
module tb_lcd_init_sequencer;

   localparam int SETUP = 2;
   localparam int ECYC  = 12;
   localparam int HOLD  = 2;
   localparam int PWR0  = 1;
   localparam int CMD0  = 1;
   localparam int PWR1  = 3;
   localparam int CMD1  = 2;
   localparam logic [7:0] EXP_CMD [8] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};

   typedef struct packed {
      logic       st;
      logic       tp;
      logic       busy;
      logic       ten;
      logic       e;
      logic       done;
      logic [7:0] db;
   } vec_t;

   logic clock;
   logic rst;
   logic [1:0] tp, st, ten, rs, rw, e, busy, done;
   logic [1:0][7:0] db;
   logic [1:0] man, man_tp, man_st, auto_tp, auto_st, noise;
   int period [2];
   int st_req [2];
   int st_ack [2];
   int clr_req [2];
   int clr_ack [2];
   int cyc = 0;
   int n_pass = 0;
   int n_total = 0;

   // monitor records
   int nrise [2], nfall [2], nten_r [2], nten_f [2];
   int rise_c [2][16], fall_c [2][16], sgap [2][16];
   int ten_r [2][16], ten_f [2][16];
   logic [7:0] fdata [2][16];
   int hold_viol [2], bad_rsrw [2], brise [2], drise [2];

   assign tp = (man & man_tp) | (~man & auto_tp);
   assign st = (man & man_st) | (~man & auto_st);

   lcd_init_sequencer #(.SETUP_CYCLES(SETUP), .E_CYCLES(ECYC), .HOLD_CYCLES(HOLD),
                        .POWERUP_TICKS(PWR0), .CMD_TICKS(CMD0)) dut0 (
      .clock(clock), .rst(rst), .start(st[0]), .timer_pulse(tp[0]),
      .timer_enable(ten[0]), .lcd_rs(rs[0]), .lcd_rw(rw[0]), .lcd_e(e[0]),
      .lcd_data(db[0]), .busy(busy[0]), .done(done[0]));

   lcd_init_sequencer #(.SETUP_CYCLES(SETUP), .E_CYCLES(ECYC), .HOLD_CYCLES(HOLD),
                        .POWERUP_TICKS(PWR1), .CMD_TICKS(CMD1)) dut1 (
      .clock(clock), .rst(rst), .start(st[1]), .timer_pulse(tp[1]),
      .timer_enable(ten[1]), .lcd_rs(rs[1]), .lcd_rw(rw[1]), .lcd_e(e[1]),
      .lcd_data(db[1]), .busy(busy[1]), .done(done[1]));

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Timer model: one pulse every period[g] clocks while enabled, restarting
   // whenever enable is low; plus optional noise outside the waits.
   initial begin : driver
      int tcnt [2];
      logic p;
      tcnt[0] = 0;
      tcnt[1] = 0;
      auto_tp = '0;
      auto_st = '0;
      st_ack[0] = 0;
      st_ack[1] = 0;
      forever begin
         @(negedge clock);
         for (int g = 0; g < 2; g++) begin
            p = 1'b0;
            if (!ten[g]) tcnt[g] = 0;
            else begin
               tcnt[g] = tcnt[g] + 1;
               if (tcnt[g] >= period[g]) begin
                  p = 1'b1;
                  tcnt[g] = 0;
               end
            end
            auto_tp[g] = p | (noise[g] & ~ten[g] & ($urandom_range(2, 0) == 0));
            if (st_req[g] != st_ack[g]) begin
               auto_st[g] = 1'b1;
               st_ack[g] = st_req[g];
            end else begin
               auto_st[g] = noise[g] & busy[g] & ($urandom_range(3, 0) == 0);
            end
         end
      end
   end

   initial begin : monitor
      logic pe [2], pt [2], pb [2], pdn [2];
      logic [7:0] pd [2];
      int lastchg [2], lastfall [2];
      for (int g = 0; g < 2; g++) begin
         pe[g] = 1'b0; pt[g] = 1'b0; pb[g] = 1'b0; pdn[g] = 1'b0; pd[g] = '0;
         lastchg[g] = 0; lastfall[g] = -100;
         clr_ack[g] = 0;
      end
      forever begin
         @(negedge clock);
         for (int g = 0; g < 2; g++) begin
            if (clr_req[g] != clr_ack[g]) begin
               clr_ack[g] = clr_req[g];
               nrise[g] = 0; nfall[g] = 0; nten_r[g] = 0; nten_f[g] = 0;
               hold_viol[g] = 0; bad_rsrw[g] = 0; brise[g] = -1; drise[g] = -1;
            end
            if (rs[g] || rw[g]) bad_rsrw[g]++;
            if (!e[g] && pe[g]) begin
               if (nfall[g] < 16) begin
                  fall_c[g][nfall[g]] = cyc;
                  fdata[g][nfall[g]] = db[g];
               end
               nfall[g]++;
               lastfall[g] = cyc;
            end
            if (db[g] != pd[g]) begin
               if (e[g] || (cyc - lastfall[g]) < HOLD) hold_viol[g]++;
               lastchg[g] = cyc;
            end
            if (e[g] && !pe[g]) begin
               if (nrise[g] < 16) begin
                  rise_c[g][nrise[g]] = cyc;
                  sgap[g][nrise[g]] = cyc - lastchg[g];
               end
               nrise[g]++;
            end
            if (ten[g] && !pt[g]) begin
               if (nten_r[g] < 16) ten_r[g][nten_r[g]] = cyc;
               nten_r[g]++;
            end
            if (!ten[g] && pt[g]) begin
               if (nten_f[g] < 16) ten_f[g][nten_f[g]] = cyc;
               nten_f[g]++;
            end
            if (busy[g] && !pb[g] && brise[g] < 0) brise[g] = cyc;
            if (done[g] && !pdn[g] && drise[g] < 0) drise[g] = cyc;
            pe[g] = e[g]; pt[g] = ten[g]; pb[g] = busy[g]; pdn[g] = done[g]; pd[g] = db[g];
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp_v);
      n_total++;
      if (act == exp_v) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
   endtask

   task automatic chk_ge(input string name, input int act, input int minv);
      n_total++;
      if (act >= minv) n_pass++;
      else $display("FAIL %s: got %0d, expected >= %0d", name, act, minv);
   endtask

   task automatic wait_done(input int g);
      int n = 0;
      while (!done[g] && n < 4000) begin
         @(negedge clock);
         n++;
      end
      chk($sformatf("done_reached[%0d]", g), int'(done[g]), 1);
   endtask

   // Expected timeline from the start-acceptance cycle s: the power-up wait
   // takes per*PWR clocks, then each command is SETUP+E+HOLD bus clocks
   // followed by a per*CMD clock wait.
   task automatic check_run(input int g, input int per);
      int pw, cm, slot;
      pw = (g == 0) ? PWR0 : PWR1;
      cm = (g == 0) ? CMD0 : CMD1;
      slot = SETUP + ECYC + HOLD + per * cm;
      chk($sformatf("e_pulse_count[%0d]", g), nrise[g], 8);
      chk($sformatf("e_fall_count[%0d]", g), nfall[g], 8);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("e_width[%0d][%0d]", g, k), fall_c[g][k] - rise_c[g][k], ECYC);
         chk($sformatf("cmd_byte[%0d][%0d]", g, k), int'(fdata[g][k]), int'(EXP_CMD[k]));
         chk($sformatf("e_rise_time[%0d][%0d]", g, k), rise_c[g][k] - brise[g],
             per * pw + SETUP + k * slot);
         chk_ge($sformatf("db_setup[%0d][%0d]", g, k), sgap[g][k], SETUP);
      end
      chk($sformatf("db_hold_violations[%0d]", g), hold_viol[g], 0);
      chk($sformatf("rs_rw_nonzero[%0d]", g), bad_rsrw[g], 0);
      chk($sformatf("timer_waits[%0d]", g), nten_r[g], 9);
      for (int k = 0; k < 9; k++) begin
         chk($sformatf("wait_len[%0d][%0d]", g, k), ten_f[g][k] - ten_r[g][k],
             per * ((k == 0) ? pw : cm));
         if (k < 8)
            chk_ge($sformatf("enable_gap[%0d][%0d]", g, k), ten_r[g][k + 1] - ten_f[g][k], 1);
      end
      chk($sformatf("done_time[%0d]", g), drise[g] - brise[g],
          per * (pw + 8 * cm) + 8 * (SETUP + ECYC + HOLD));
      chk($sformatf("busy_after_done[%0d]", g), int'(busy[g]), 0);
      chk($sformatf("timer_en_after_done[%0d]", g), int'(ten[g]), 0);
      chk($sformatf("final_db[%0d]", g), int'(db[g]), 8'h0C);
   endtask

   task automatic run_seq(input int g, input int per, input logic nz);
      int n = 0;
      @(posedge clock);
      period[g] = per;
      noise[g] = nz;
      clr_req[g]++;
      st_req[g]++;
      while (!busy[g] && n < 10) begin
         @(negedge clock);
         n++;
      end
      chk($sformatf("start_busy[%0d]", g), int'(busy[g]), 1);
      chk($sformatf("start_done_clear[%0d]", g), int'(done[g]), 0);
      chk($sformatf("start_timer_en[%0d]", g), int'(ten[g]), 1);
      wait_done(g);
      noise[g] = 1'b0;
      repeat (3) @(negedge clock);
      check_run(g, per);
   endtask

   initial begin : main
      vec_t vecs [9];
      int n;
      //           st    tp    busy  ten   e     done  db
      vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
      vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
      vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
      vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h30};
      vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h30};
      vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h30};
      vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h30};

      rst = 1'b0;
      man = 2'b11; man_tp = '0; man_st = '0; noise = '0;
      period[0] = 5; period[1] = 5;
      st_req[0] = 0; st_req[1] = 0; clr_req[0] = 0; clr_req[1] = 0;

      repeat (3) @(negedge clock);
      chk("reset_busy", int'(busy[0]), 0);
      chk("reset_done", int'(done[0]), 0);
      chk("reset_timer_en", int'(ten[0]), 0);
      chk("reset_e", int'(e[0]), 0);
      chk("reset_db", int'(db[0]), 0);
      rst = 1'b1;
      man[1] = 1'b0;

      for (int i = 0; i < 9; i++) begin
         man_st[0] = vecs[i].st;
         man_tp[0] = vecs[i].tp;
         @(negedge clock);
         chk($sformatf("vec%0d_busy", i), int'(busy[0]), int'(vecs[i].busy));
         chk($sformatf("vec%0d_timer_en", i), int'(ten[0]), int'(vecs[i].ten));
         chk($sformatf("vec%0d_e", i), int'(e[0]), int'(vecs[i].e));
         chk($sformatf("vec%0d_done", i), int'(done[0]), int'(vecs[i].done));
         chk($sformatf("vec%0d_db", i), int'(db[0]), int'(vecs[i].db));
      end
      man_st[0] = 1'b0;
      man_tp[0] = 1'b0;
      man[0] = 1'b0;
      wait_done(0);

      // nominal run, started from DONE
      run_seq(0, 5, 1'b0);
      // slower power-up / two-tick gaps
      run_seq(1, 5, 1'b0);
      // random timer periods with spurious pulses and starts while busy
      for (int r = 0; r < 2; r++) begin
         run_seq(0, int'($urandom_range(9, 2)), 1'b1);
         run_seq(1, int'($urandom_range(9, 2)), 1'b1);
      end

      // reset in the middle of command 3's E pulse
      @(posedge clock);
      period[0] = 5;
      clr_req[0]++;
      st_req[0]++;
      n = 0;
      while (!busy[0] && n < 10) begin
         @(negedge clock);
         n++;
      end
      n = 0;
      while (nrise[0] < 4 && n < 2000) begin
         @(negedge clock);
         n++;
      end
      chk("abort_reached_cmd3", nrise[0], 4);
      repeat (3) @(negedge clock);
      chk("abort_e_before_reset", int'(e[0]), 1);
      rst = 1'b0;
      #1;
      chk("abort_e", int'(e[0]), 0);
      chk("abort_busy", int'(busy[0]), 0);
      chk("abort_done", int'(done[0]), 0);
      chk("abort_timer_en", int'(ten[0]), 0);
      @(negedge clock);
      rst = 1'b1;
      repeat (2) @(negedge clock);
      chk("abort_idle_e", int'(e[0]), 0);
      run_seq(0, 5, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
